cpu_sequencer: RTL and testbench

Fetch/decode/execute sequencer for the 8-bit accumulator processor. It owns the program counter, instruction register, accumulator and carry flag. It fetches 12-bit instructions from program memory and addresses data memory. It drives the ALU's operation code, accumulator operand and carry-in, and writes the ALU result and carry-out back into its own registers. It therefore sits directly upstream of the ALU, which it feeds, and directly downstream of it, consuming its result.

---
 rtl/cpu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns PC, IR, ACC and the carry flag; drives the external ALU and consumes
// its result in the write-back state.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   advance enable (0 = hold all state)
//   pm_addr    out  [7:0]  program-memory address (= PC)
//   pm_data    in   [11:0] instruction from synchronous ROM (one cycle latency)
//   dm_addr    out  [7:0]  data-memory address (= IR[7:0])
//   dm_we      out         data-memory write strobe (EXEC of ST only)
//   dm_wdata   out  [7:0]  data-memory write data (= ACC)
//   alu_code   out  [2:0]  ALU operation, `ALU_* encoding
//   alu_accu   out  [7:0]  ALU accumulator operand (= ACC)
//   alu_ci     out         ALU carry-in (carry flag for ADC/SBB)
//   alu_out    in   [7:0]  ALU result, captured into ACC in WB
//   alu_co     in          ALU carry-out, captured for ADD/ADC/SUB/SBB
//   zero       out         ACC == 0
//   carry      out         carry flag register
//   halted     out         1 while in the HALT state

`ifndef ALU_LD
`define ALU_LD  3'd0
`define ALU_ADD 3'd1
`define ALU_SUB 3'd2
`define ALU_AND 3'd3
`define ALU_OR  3'd4
`define ALU_XOR 3'd5
`define ALU_NOT 3'd6
`endif

module cpu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [7:0]  pm_addr,
    input  logic [11:0] pm_data,
    output logic [7:0]  dm_addr,
    output logic        dm_we,
    output logic [7:0]  dm_wdata,
    output logic [2:0]  alu_code,
    output logic [7:0]  alu_accu,
    output logic        alu_ci,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    output logic        zero,
    output logic        carry,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADC  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SBB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_CLC  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    logic [7:0]  acc_q, acc_d;
    logic        carry_q, carry_d;
    logic        we_c;
    logic [3:0]  opcode;

    assign opcode = ir_q[11:8];

    function automatic logic [2:0] alu_decode(input logic [3:0] op);
        case (op)
            OP_LD:          return `ALU_LD;
            OP_ADD, OP_ADC: return `ALU_ADD;
            OP_SUB, OP_SBB: return `ALU_SUB;
            OP_AND:         return `ALU_AND;
            OP_OR:          return `ALU_OR;
            OP_XOR:         return `ALU_XOR;
            OP_NOT:         return `ALU_NOT;
            default:        return `ALU_LD;
        endcase
    endfunction

    // Opcodes that need a data-memory read and a write-back cycle.
    function automatic logic needs_wb(input logic [3:0] op);
        return (op == OP_LD) || ((op >= OP_ADD) && (op <= OP_NOT));
    endfunction

    // Opcodes whose carry-out is architecturally visible.
    function automatic logic writes_carry(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SBB);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 12'h000;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        we_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = pm_data;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (needs_wb(opcode)) begin
                    state_d = S_WB;
                end else begin
                    case (opcode)
                        OP_ST:   we_c = 1'b1;
                        OP_JMP:  pc_d = ir_q[7:0];
                        OP_JZ:   if (zero) pc_d = ir_q[7:0];
                        OP_JC:   if (carry_q) pc_d = ir_q[7:0];
                        OP_CLC:  carry_d = 1'b0;
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_WB: begin
                acc_d = alu_out;
                if (writes_carry(opcode)) begin
                    carry_d = alu_co;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pm_addr  = pc_q;
    assign dm_addr  = ir_q[7:0];
    // A stalled cycle must not repeat or extend the store.
    assign dm_we    = we_c & en;
    assign dm_wdata = acc_q;
    assign alu_code = alu_decode(opcode);
    assign alu_accu = acc_q;
    assign alu_ci   = ((opcode == OP_ADC) || (opcode == OP_SBB)) & carry_q;
    assign zero     = (acc_q == 8'h00);
    assign carry    = carry_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: models the ROM, data memory and ALU,
// queues hand-computed expectations per test and checks them from monitors.

`ifndef ALU_LD
`define ALU_LD  3'd0
`define ALU_ADD 3'd1
`define ALU_SUB 3'd2
`define ALU_AND 3'd3
`define ALU_OR  3'd4
`define ALU_XOR 3'd5
`define ALU_NOT 3'd6
`endif

module tb_cpu_sequencer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b1;
    logic [7:0]  pm_addr;
    logic [11:0] pm_data;
    logic [7:0]  dm_addr;
    logic        dm_we;
    logic [7:0]  dm_wdata;
    logic [2:0]  alu_code;
    logic [7:0]  alu_accu;
    logic        alu_ci;
    logic [7:0]  alu_out;
    logic        alu_co;
    logic        zero;
    logic        carry;
    logic        halted;

    logic [11:0] rom  [256];
    logic [7:0]  dmem [256];
    logic [7:0]  dm_rdata;
    logic [8:0]  wide;

    int cyc    = 0;
    int t0     = 0;
    bit active = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         rel;
        int         kind;   // 0: pm/acc/carry/zero/halted, 1: alu_code/dm_addr/alu_ci
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       h;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } st_t;

    exp_t  exp_q[$];
    st_t   st_q[$];
    string rst_q[$];

    cpu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pm_addr  (pm_addr),
        .pm_data  (pm_data),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_wdata (dm_wdata),
        .alu_code (alu_code),
        .alu_accu (alu_accu),
        .alu_ci   (alu_ci),
        .alu_out  (alu_out),
        .alu_co   (alu_co),
        .zero     (zero),
        .carry    (carry),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM and data memory.
    always @(posedge clk) pm_data <= rom[pm_addr];
    always @(posedge clk) if (dm_we === 1'b1) dmem[dm_addr] <= dm_wdata;
    assign dm_rdata = dmem[dm_addr];

    // ALU model: SUB carry-out is the borrow.
    always_comb begin
        wide    = 9'h000;
        alu_out = 8'h00;
        alu_co  = 1'b0;
        case (alu_code)
            `ALU_ADD: begin
                wide    = {1'b0, alu_accu} + {1'b0, dm_rdata} + {8'h00, alu_ci};
                alu_out = wide[7:0];
                alu_co  = wide[8];
            end
            `ALU_SUB: begin
                wide    = {1'b0, alu_accu} - {1'b0, dm_rdata} - {8'h00, alu_ci};
                alu_out = wide[7:0];
                alu_co  = wide[8];
            end
            `ALU_AND: alu_out = alu_accu & dm_rdata;
            `ALU_OR:  alu_out = alu_accu | dm_rdata;
            `ALU_XOR: alu_out = alu_accu ^ dm_rdata;
            `ALU_NOT: alu_out = ~alu_accu;
            default:  alu_out = dm_rdata;
        endcase
    end

    // State / ALU-drive monitor.
    always @(negedge clk) begin
        int rel;
        if (active) begin
            rel = cyc - t0;
            while (exp_q.size() > 0 && exp_q[0].rel <= rel) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (e.rel != rel) begin
                    errors++;
                    $display("FAIL %s: checked at r%0d, required at r%0d", e.name, rel, e.rel);
                end else if (e.kind == 0) begin
                    if ({pm_addr, alu_accu, carry, zero, halted} !==
                        {e.a, e.b, e.c, (e.b == 8'h00), e.h}) begin
                        errors++;
                        $display("FAIL %s r%0d: pm=%h acc=%h c=%b z=%b h=%b, want pm=%h acc=%h c=%b z=%b h=%b",
                                 e.name, rel, pm_addr, alu_accu, carry, zero, halted,
                                 e.a, e.b, e.c, (e.b == 8'h00), e.h);
                    end
                end else begin
                    if ({alu_code, dm_addr, alu_ci} !== {e.a[2:0], e.b, e.c}) begin
                        errors++;
                        $display("FAIL %s r%0d: code=%0d dm_addr=%h ci=%b, want code=%0d dm_addr=%h ci=%b",
                                 e.name, rel, alu_code, dm_addr, alu_ci, e.a[2:0], e.b, e.c);
                    end
                end
            end
        end
    end

    // Store monitor: every asserted strobe must match a queued store.
    always @(negedge clk) begin
        if (dm_we === 1'b1) begin
            st_t s;
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_store: dm_we=1 addr=%h data=%h, want no strobe", dm_addr, dm_wdata);
            end else begin
                s = st_q.pop_front();
                if ({dm_addr, dm_wdata} !== {s.addr, s.data}) begin
                    errors++;
                    $display("FAIL store: addr=%h data=%h, want addr=%h data=%h",
                             dm_addr, dm_wdata, s.addr, s.data);
                end
            end
        end
    end

    // Reset monitor: outputs must reach reset values without a clock edge.
    always @(negedge rst_n) begin
        string nm;
        #1;
        nm = (rst_q.size() > 0) ? rst_q.pop_front() : "reset";
        checks++;
        if ({pm_addr, alu_accu, dm_wdata, dm_we, halted, zero, carry, alu_code, alu_ci} !==
            {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, `ALU_LD, 1'b0}) begin
            errors++;
            $display("FAIL %s: pm=%h acc=%h we=%b h=%b z=%b c=%b code=%0d ci=%b, want pm=00 acc=00 we=0 h=0 z=1 c=0 code=%0d ci=0",
                     nm, pm_addr, alu_accu, dm_we, halted, zero, carry, alu_code, alu_ci, `ALU_LD);
        end
    end

    task automatic exp_state(input int rel, input logic [7:0] pm, input logic [7:0] acc,
                             input logic c, input logic h, input string name);
        exp_t e;
        e.rel = rel; e.kind = 0; e.a = pm; e.b = acc; e.c = c; e.h = h; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic exp_alu(input int rel, input logic [2:0] code, input logic [7:0] da,
                           input logic ci, input string name);
        exp_t e;
        e.rel = rel; e.kind = 1; e.a = {5'b0, code}; e.b = da; e.c = ci; e.h = 1'b0; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic exp_store(input logic [7:0] addr, input logic [7:0] data);
        st_t s;
        s.addr = addr; s.data = data;
        st_q.push_back(s);
    endtask

    // Assert reset (checked by the reset monitor) and clear both memories.
    task automatic begin_test(input string name);
        active = 1'b0;
        en     = 1'b1;
        rst_q.push_back(name);
        rst_n  = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 12'h000;
            dmem[i] = 8'h00;
        end
    endtask

    // Release reset two time units after a rising edge; the next sample is r0.
    task automatic go();
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        t0     = cyc;
        active = 1'b1;
    endtask

    task automatic wait_rel(input int n);
        while ((cyc - t0) < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic end_test(input int n, input string name);
        wait_rel(n);
        checks++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d state and %0d store expectations unmet, want 0 and 0",
                     name, exp_q.size(), st_q.size());
            exp_q.delete();
            st_q.delete();
        end
    endtask

    initial begin
        // Arithmetic with carry
        begin_test("reset_arith");
        rom[0] = 12'h110; rom[1] = 12'h311; rom[2] = 12'h412; rom[3] = 12'hF00;
        dmem[8'h10] = 8'hF0; dmem[8'h11] = 8'h20; dmem[8'h12] = 8'h00;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "arith_start");
        exp_alu(2, `ALU_LD, 8'h10, 1'b0, "ld_exec");
        exp_state(4, 8'h01, 8'hF0, 1'b0, 1'b0, "ld_f0");
        exp_alu(6, `ALU_ADD, 8'h11, 1'b0, "add_exec");
        exp_state(8, 8'h02, 8'h10, 1'b1, 1'b0, "add_carry");
        exp_alu(10, `ALU_ADD, 8'h12, 1'b1, "adc_exec_ci");
        exp_state(12, 8'h03, 8'h11, 1'b0, 1'b0, "adc_result");
        exp_state(15, 8'h04, 8'h11, 1'b0, 1'b1, "arith_halt");
        end_test(16, "arith");

        // Subtract with borrow, SBB, CLC
        begin_test("reset_sub");
        rom[0] = 12'h120; rom[1] = 12'h521; rom[2] = 12'h622; rom[3] = 12'hE00; rom[4] = 12'hF00;
        dmem[8'h20] = 8'h05; dmem[8'h21] = 8'h06; dmem[8'h22] = 8'hFF;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "sub_start");
        exp_state(4, 8'h01, 8'h05, 1'b0, 1'b0, "ld_05");
        exp_alu(6, `ALU_SUB, 8'h21, 1'b0, "sub_exec");
        exp_state(8, 8'h02, 8'hFF, 1'b1, 1'b0, "sub_borrow");
        exp_alu(10, `ALU_SUB, 8'h22, 1'b1, "sbb_exec_ci");
        exp_state(12, 8'h03, 8'hFF, 1'b1, 1'b0, "sbb_result");
        exp_alu(14, `ALU_LD, 8'h00, 1'b0, "clc_exec");
        exp_state(15, 8'h04, 8'hFF, 1'b0, 1'b0, "clc_clears");
        exp_state(18, 8'h05, 8'hFF, 1'b0, 1'b1, "sub_halt");
        end_test(19, "sub");

        // Branches
        begin_test("reset_branch");
        rom[0] = 12'hC40; rom[8'h40] = 12'hD80; rom[8'h41] = 12'hBFF; rom[8'hFF] = 12'h000;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "branch_start");
        exp_state(2, 8'h01, 8'h00, 1'b0, 1'b0, "jz_exec_pc_inc");
        exp_state(3, 8'h40, 8'h00, 1'b0, 1'b0, "jz_taken");
        exp_state(6, 8'h41, 8'h00, 1'b0, 1'b0, "jc_not_taken");
        exp_state(9, 8'hFF, 8'h00, 1'b0, 1'b0, "jmp_ff");
        exp_state(12, 8'h00, 8'h00, 1'b0, 1'b0, "pc_wrap");
        end_test(13, "branch");

        // Store, then JZ not taken
        begin_test("reset_store");
        rom[0] = 12'h130; rom[1] = 12'h233; rom[2] = 12'hC10; rom[3] = 12'hF00;
        dmem[8'h30] = 8'h5A;
        go();
        exp_store(8'h33, 8'h5A);
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "store_start");
        exp_state(4, 8'h01, 8'h5A, 1'b0, 1'b0, "ld_5a");
        exp_alu(6, `ALU_LD, 8'h33, 1'b0, "st_exec");
        exp_state(7, 8'h02, 8'h5A, 1'b0, 1'b0, "st_3cyc");
        exp_state(10, 8'h03, 8'h5A, 1'b0, 1'b0, "jz_not_taken");
        exp_state(13, 8'h04, 8'h5A, 1'b0, 1'b1, "store_halt");
        end_test(14, "store");

        // Stall for 3 cycles in EXEC of ADD, then JC taken
        begin_test("reset_stall");
        rom[0] = 12'h110; rom[1] = 12'h311; rom[2] = 12'hD50; rom[8'h50] = 12'hF00;
        dmem[8'h10] = 8'h70; dmem[8'h11] = 8'h95;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "stall_start");
        exp_state(4, 8'h01, 8'h70, 1'b0, 1'b0, "ld_70");
        exp_alu(6, `ALU_ADD, 8'h11, 1'b0, "add_exec_pre_stall");
        exp_state(8, 8'h02, 8'h70, 1'b0, 1'b0, "stall_holds_acc");
        exp_alu(9, `ALU_ADD, 8'h11, 1'b0, "add_exec_stalled");
        exp_state(11, 8'h02, 8'h05, 1'b1, 1'b0, "add_after_stall");
        exp_state(14, 8'h50, 8'h05, 1'b1, 1'b0, "jc_taken");
        exp_state(17, 8'h51, 8'h05, 1'b1, 1'b1, "stall_halt");
        wait_rel(6);
        en = 1'b0;
        wait_rel(9);
        en = 1'b1;
        end_test(18, "stall");

        // Reset during write-back
        begin_test("reset_pre_wb");
        rom[0] = 12'h110; rom[1] = 12'h311;
        dmem[8'h10] = 8'h70; dmem[8'h11] = 8'h95;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "wb_start");
        exp_state(4, 8'h01, 8'h70, 1'b0, 1'b0, "acc_before_wb");
        end_test(7, "pre_wb");
        begin_test("reset_mid_wb");
        rom[0] = 12'h110; rom[1] = 12'h311;
        dmem[8'h10] = 8'h70; dmem[8'h11] = 8'h95;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "wb_discarded");
        end_test(1, "post_wb");

        // HALT at ROM[5], held indefinitely, reset restarts at 0
        begin_test("reset_halt");
        rom[5] = 12'hF00;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "halt_start");
        exp_state(15, 8'h05, 8'h00, 1'b0, 1'b0, "halt_fetch");
        exp_state(17, 8'h06, 8'h00, 1'b0, 1'b0, "halt_exec");
        exp_state(18, 8'h06, 8'h00, 1'b0, 1'b1, "halted_4th");
        exp_state(60, 8'h06, 8'h00, 1'b0, 1'b1, "halt_hold");
        end_test(61, "halt");
        begin_test("reset_from_halt");
        rom[5] = 12'hF00;
        go();
        exp_state(0, 8'h00, 8'h00, 1'b0, 1'b0, "restart_pc0");
        exp_state(3, 8'h01, 8'h00, 1'b0, 1'b0, "restart_nop");
        end_test(4, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
